// File: rtl/crc16_serial_engine.sv
// -----------------------------------------------------------------------------
// crc16_serial_engine
//   Shared CRC-16/CCITT-FALSE engine (poly 0x1021, init 0xFFFF, MSB-first,
//   no reflection, no output XOR). Accepts one byte per request and folds it
//   into the running CRC over 8/BITS_PER_CYCLE cycles. Only the committed CRC
//   is published; the partially folded value lives in an internal work reg.
//
// Ports
//   clk             in   1   system clock
//   rst_n           in   1   asynchronous active-low reset
//   crc_init        in   1   level: reload INIT_VALUE, abort any byte in flight
//   crc_data        in   8   byte to fold, sampled only when accepted
//   crc_data_valid  in   1   request to fold crc_data (ignored while busy)
//   crc_value       out  16  committed CRC
//   crc_busy        out  1   registered, high while a byte is being folded
//   crc_done        out  1   one-cycle pulse coincident with crc_value update
// -----------------------------------------------------------------------------
module crc16_serial_engine #(
    parameter logic [15:0] POLY           = 16'h1021,
    parameter logic [15:0] INIT_VALUE     = 16'hFFFF,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crc_init,
    input  logic [7:0]  crc_data,
    input  logic        crc_data_valid,
    output logic [15:0] crc_value,
    output logic        crc_busy,
    output logic        crc_done
);

    localparam int unsigned CRC_W  = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam bit BPC_LEGAL = (BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) ||
                               (BITS_PER_CYCLE == 4) || (BITS_PER_CYCLE == 8);
    // Fall back to a legal value so the rest of elaboration stays well defined
    localparam int unsigned BPC      = BPC_LEGAL ? BITS_PER_CYCLE : 1;
    localparam int unsigned BEATS    = DATA_W / BPC;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BEATS - 1);

    generate
        if (!BPC_LEGAL) begin : g_bad_bpc
            $error("crc16_serial_engine: BITS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CRC_W-1:0]    r_work;
    logic [CRC_W-1:0]    w_work_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [CRC_W-1:0]    r_value;
    logic [CRC_W-1:0]    w_value_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;

    logic [CRC_W-1:0]    w_fold_work;
    logic [DATA_W-1:0]   w_fold_shift;

    // Fold the BPC most significant bits of shift into work, MSB first
    function automatic logic [CRC_W+DATA_W-1:0] fold_bits(
        input logic [CRC_W-1:0]  work_in,
        input logic [DATA_W-1:0] shift_in
    );
        logic [CRC_W-1:0]  w;
        logic [DATA_W-1:0] s;
        logic              fb;
        w = work_in;
        s = shift_in;
        for (int unsigned i = 0; i < BPC; i++) begin
            fb = w[CRC_W-1] ^ s[DATA_W-1];
            w  = {w[CRC_W-2:0], 1'b0} ^ (fb ? POLY : 16'h0000);
            s  = {s[DATA_W-2:0], 1'b0};
        end
        return {w, s};
    endfunction

    assign {w_fold_work, w_fold_shift} = fold_bits(r_work, r_shift);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_work  <= INIT_VALUE;
            r_shift <= '0;
            r_count <= '0;
            r_value <= INIT_VALUE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
            r_value <= w_value_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and next-output logic; crc_init has priority in every state
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_value_nxt = r_value;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (crc_init) begin
                    w_value_nxt = INIT_VALUE;
                    w_work_nxt  = INIT_VALUE;
                end else if (crc_data_valid) begin
                    w_shift_nxt = crc_data;
                    w_work_nxt  = r_value;
                    w_count_nxt = CNT_LOAD;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (crc_init) begin
                    // Abort: partial byte is discarded and no done pulse is given
                    w_value_nxt = INIT_VALUE;
                    w_work_nxt  = INIT_VALUE;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_work_nxt  = w_fold_work;
                    w_shift_nxt = w_fold_shift;
                    if (r_count == '0) begin
                        w_value_nxt = w_fold_work;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = r_count - CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign crc_value = r_value;
    assign crc_busy  = r_busy;
    assign crc_done  = r_done;

endmodule
